// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and oversampling constants.
// Shared by the transmitter, receiver and baud generator.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

  localparam int OVS       = 16;
  localparam int START_MID = 7;
  localparam int DVSR_W    = 11;

endpackage

// File: rtl/uart_rx_core_if.sv
// Register-file side of the UART receiver: baud/stop configuration in, received byte and status out.
interface uart_rx_core_if #(
  parameter int DBIT = 8
);
  import uart_pkg::*;

  logic [DVSR_W-1:0] dvsr;
  logic              snum;
  logic [DBIT-1:0]   d_rx;
  logic              rx_done;
  logic              rxing;
  logic              frame_err;

  modport master (
    input  dvsr, snum,
    output d_rx, rx_done, rxing, frame_err
  );

  modport slave (
    output dvsr, snum,
    input  d_rx, rx_done, rxing, frame_err
  );

endinterface

// File: rtl/uart_baud_gen.sv
// Oversampling tick generator: one-clk tick every dvsr+1 cycles.
// Also used by the transmitter.
module uart_baud_gen
  import uart_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DVSR_W-1:0] dvsr,
  output logic              tick
);

  logic [DVSR_W-1:0] cnt;
  logic [DVSR_W-1:0] dvsr_q;

  // The period is captured only at a wrap, so a new dvsr never strands cnt above the limit.
  assign tick = (cnt == dvsr_q);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      dvsr_q <= '0;
    end else if (tick) begin
      cnt    <= '0;
      dvsr_q <= dvsr;
    end else begin
      cnt    <= cnt + DVSR_W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: synchronises rx, finds the start bit mid-point and shifts in DBIT data bits LSB first.
// It then checks one or two stop bits.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SYNC_FF = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rx,
  uart_rx_core_if.master bus
);

  localparam int N_W = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [4:0]     S_MID  = 5'(START_MID);
  localparam logic [4:0]     S_BIT  = 5'(OVS - 1);
  localparam logic [4:0]     S_BIT2 = 5'(2 * OVS - 1);
  localparam logic [N_W-1:0] N_LAST = N_W'(DBIT - 1);

  logic tick;

  uart_baud_gen u_baud_gen (
    .clk  (clk),
    .rst  (rst),
    .dvsr (bus.dvsr),
    .tick (tick)
  );

  // Synchroniser resets to the idle level so reset release never looks like a start edge.
  logic [SYNC_FF-1:0] sync_q;
  logic               rx_s;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '1;
    else     sync_q <= {sync_q[SYNC_FF-2:0], rx};
  end

  assign rx_s = sync_q[SYNC_FF-1];

  rx_state_t       state;
  logic [4:0]      s_cnt;
  logic [N_W-1:0]  n;
  logic [DBIT-1:0] shreg;
  logic            snum_q;
  logic            stop_bad;
  logic [DBIT-1:0] d_rx_q;
  logic            rx_done_q;
  logic            rxing_q;
  logic            frame_err_q;
  logic [4:0]      stop_last;

  assign stop_last = snum_q ? S_BIT2 : S_BIT;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      s_cnt       <= '0;
      n           <= '0;
      shreg       <= '0;
      snum_q      <= 1'b0;
      stop_bad    <= 1'b0;
      d_rx_q      <= '0;
      rx_done_q   <= 1'b0;
      rxing_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
      unique case (state)
        IDLE: begin
          rxing_q <= 1'b0;
          if (!rx_s) begin
            state <= START;
            s_cnt <= '0;
          end
        end
        START: if (tick) begin
          if (s_cnt == S_MID) begin
            s_cnt <= '0;
            if (!rx_s) begin
              state    <= DATA;
              n        <= '0;
              rxing_q  <= 1'b1;
              snum_q   <= bus.snum;
              stop_bad <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end else begin
            s_cnt <= s_cnt + 5'd1;
          end
        end
        DATA: if (tick) begin
          if (s_cnt == S_BIT) begin
            s_cnt <= '0;
            shreg <= {rx_s, shreg[DBIT-1:1]};
            if (n == N_LAST) state <= STOP;
            else             n     <= n + N_W'(1);
          end else begin
            s_cnt <= s_cnt + 5'd1;
          end
        end
        STOP: if (tick) begin
          if (s_cnt == stop_last) begin
            // Final stop sample folds straight into frame_err; earlier ones accumulate in stop_bad.
            state       <= IDLE;
            s_cnt       <= '0;
            d_rx_q      <= shreg;
            rx_done_q   <= 1'b1;
            frame_err_q <= stop_bad | ~rx_s;
          end else begin
            s_cnt <= s_cnt + 5'd1;
            if (s_cnt == S_BIT && !rx_s) stop_bad <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.d_rx      = d_rx_q;
  assign bus.rx_done   = rx_done_q;
  assign bus.rxing     = rxing_q;
  assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: drives serial frames on rx and compares received bytes,
// framing status and timing with values computed from the frame rules.
module tb_uart_rx_core;
  import uart_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;

  uart_rx_core_if #(.DBIT(8)) bus ();

  uart_rx_core #(.DBIT(8), .SYNC_FF(2)) dut (
    .clk (clk),
    .rst (rst),
    .rx  (rx),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int bit_clks = 432;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] d;
    logic       err;
    int         cyc;
  } done_t;

  done_t dq[$];
  int    rd_idx       = 0;
  int    orphan_err   = 0;
  int    rxing_cycles = 0;

  // Monitor samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (bus.rx_done === 1'b1) dq.push_back('{bus.d_rx, bus.frame_err, cyc});
    if (bus.frame_err === 1'b1 && bus.rx_done !== 1'b1) orphan_err++;
    if (bus.rxing === 1'b1) rxing_cycles++;
  end

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (bit_clks) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit s1, input bit s2, input bit two);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(s1);
    if (two) drive_bit(s2);
    rx = 1'b1;
  endtask

  task automatic get_done(output done_t e, output bit ok);
    int n = 0;
    ok = 1'b0;
    e  = '{8'h00, 1'b0, 0};
    while (dq.size() <= rd_idx && n < 20 * bit_clks) begin
      @(negedge clk);
      n++;
    end
    if (dq.size() > rd_idx) begin
      e = dq[rd_idx];
      rd_idx++;
      ok = 1'b1;
    end
  endtask

  task automatic set_dvsr(input int v);
    bus.dvsr = 11'(v);
    bit_clks = (v + 1) * OVS;
    repeat (40) @(negedge clk);
  endtask

  task automatic test_reset;
    bus.dvsr = 11'd26;
    bus.snum = 1'b0;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (bus.d_rx !== 8'h00) begin failures++; $display("FAIL reset_d_rx got=%h exp=00", bus.d_rx); end
    checks++; if (bus.rx_done !== 1'b0) begin failures++; $display("FAIL reset_rx_done got=%b exp=0", bus.rx_done); end
    checks++; if (bus.rxing !== 1'b0) begin failures++; $display("FAIL reset_rxing got=%b exp=0", bus.rxing); end
    checks++; if (bus.frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err got=%b exp=0", bus.frame_err); end
    rst = 1'b0;
    set_dvsr(26);
  endtask

  task automatic test_single;
    done_t e; bit ok; int r0;
    r0 = rxing_cycles;
    send_frame(8'h55, 1'b1, 1'b1, 1'b0);
    get_done(e, ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_timeout got=none exp=rx_done"); end
    checks++; if (e.d !== 8'h55) begin failures++; $display("FAIL single_data got=%h exp=55", e.d); end
    checks++; if (e.err !== 1'b0) begin failures++; $display("FAIL single_err got=%b exp=0", e.err); end
    repeat (2 * bit_clks) @(negedge clk);
    checks++; if (dq.size() != rd_idx) begin failures++; $display("FAIL single_pulses got=%0d exp=0 extra", dq.size() - rd_idx); end
    checks++; if (bus.rxing !== 1'b0) begin failures++; $display("FAIL single_rxing_low got=%b exp=0", bus.rxing); end
    // Start mid-point to stop mid-point is nine bit times (~3888 clk at dvsr=26), plus one tick of phase.
    checks++;
    if (rxing_cycles - r0 < 3800 || rxing_cycles - r0 > 4104) begin
      failures++; $display("FAIL single_rxing_len got=%0d exp=3800..4104", rxing_cycles - r0);
    end
  endtask

  task automatic test_back_to_back;
    done_t e; bit ok;
    send_frame(8'hA3, 1'b1, 1'b1, 1'b0);
    send_frame(8'h0F, 1'b1, 1'b1, 1'b0);
    get_done(e, ok);
    checks++; if (!ok || e.d !== 8'hA3 || e.err !== 1'b0) begin failures++; $display("FAIL b2b_first got=%h/%b ok=%b exp=a3/0", e.d, e.err, ok); end
    get_done(e, ok);
    checks++; if (!ok || e.d !== 8'h0F || e.err !== 1'b0) begin failures++; $display("FAIL b2b_second got=%h/%b ok=%b exp=0f/0", e.d, e.err, ok); end
  endtask

  task automatic test_glitch;
    int base; int r0;
    base = dq.size();
    r0   = rxing_cycles;
    rx = 1'b0;
    repeat (4 * 27) @(negedge clk);
    rx = 1'b1;
    repeat (2 * bit_clks) @(negedge clk);
    checks++; if (dq.size() != base) begin failures++; $display("FAIL glitch_done got=%0d exp=0 pulses", dq.size() - base); end
    checks++; if (rxing_cycles != r0) begin failures++; $display("FAIL glitch_rxing got=%0d exp=0 cycles", rxing_cycles - r0); end
    checks++; if (bus.d_rx !== 8'h0F) begin failures++; $display("FAIL glitch_d_rx got=%h exp=0f", bus.d_rx); end
  endtask

  task automatic test_two_stop_err;
    done_t e; bit ok;
    bus.snum = 1'b1;
    send_frame(8'hC6, 1'b1, 1'b0, 1'b1);
    bus.snum = 1'b0;
    get_done(e, ok);
    checks++; if (!ok || e.d !== 8'hC6) begin failures++; $display("FAIL stop2_data got=%h ok=%b exp=c6", e.d, ok); end
    checks++; if (e.err !== 1'b1) begin failures++; $display("FAIL stop2_frame_err got=%b exp=1", e.err); end
    // A low second stop bit can look like a new start edge; discard whatever follows.
    repeat (14 * bit_clks) @(negedge clk);
    rd_idx = dq.size();
  endtask

  task automatic test_break;
    int base;
    base = dq.size();
    rx = 1'b0;
    repeat (25 * bit_clks) @(negedge clk);
    checks++; if (dq.size() - base < 2) begin failures++; $display("FAIL break_count got=%0d exp>=2", dq.size() - base); end
    for (int i = base; i < dq.size(); i++) begin
      checks++;
      if (dq[i].d !== 8'h00 || dq[i].err !== 1'b1) begin
        failures++; $display("FAIL break_frame got=%h/%b exp=00/1", dq[i].d, dq[i].err);
      end
    end
    rx = 1'b1;
    repeat (14 * bit_clks) @(negedge clk);
    rd_idx = dq.size();
  endtask

  task automatic test_reset_mid;
    done_t e; bit ok; int base;
    base = dq.size();
    fork
      send_frame(8'hFF, 1'b1, 1'b1, 1'b0);
      begin
        repeat (4 * bit_clks) @(negedge clk);
        checks++; if (bus.rxing !== 1'b1) begin failures++; $display("FAIL rstmid_rxing_before got=%b exp=1", bus.rxing); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (bus.rxing !== 1'b0) begin failures++; $display("FAIL rstmid_rxing_after got=%b exp=0", bus.rxing); end
      end
    join
    repeat (2 * bit_clks) @(negedge clk);
    checks++; if (dq.size() != base) begin failures++; $display("FAIL rstmid_no_done got=%0d exp=0 pulses", dq.size() - base); end
    rd_idx = dq.size();
    send_frame(8'h81, 1'b1, 1'b1, 1'b0);
    get_done(e, ok);
    checks++; if (!ok || e.d !== 8'h81 || e.err !== 1'b0) begin failures++; $display("FAIL rstmid_next got=%h/%b ok=%b exp=81/0", e.d, e.err, ok); end
  endtask

  task automatic test_fast;
    done_t e; bit ok; int start_cyc; int lat;
    set_dvsr(0);
    start_cyc = cyc;
    send_frame(8'h3C, 1'b1, 1'b1, 1'b0);
    get_done(e, ok);
    checks++; if (!ok || e.d !== 8'h3C) begin failures++; $display("FAIL fast_data got=%h ok=%b exp=3c", e.d, ok); end
    // 2 sync + 1 idle + 8 start ticks + 8*16 data ticks + 16 stop ticks = 155 clk.
    lat = e.cyc - start_cyc;
    checks++; if (lat < 154 || lat > 156) begin failures++; $display("FAIL fast_latency got=%0d exp=154..156", lat); end
    set_dvsr(26);
  endtask

  task automatic test_random;
    logic [7:0] exp_q[$];
    done_t e; bit ok; logic [7:0] d; logic [7:0] x;
    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom_range(0, 255));
      bus.snum = 1'($urandom_range(0, 1));
      exp_q.push_back(d);
      send_frame(d, 1'b1, 1'b1, bus.snum);
    end
    bus.snum = 1'b0;
    for (int i = 0; i < 8; i++) begin
      x = exp_q.pop_front();
      get_done(e, ok);
      checks++;
      if (!ok || e.d !== x || e.err !== 1'b0) begin
        failures++; $display("FAIL random_frame%0d got=%h/%b ok=%b exp=%h/0", i, e.d, e.err, ok, x);
      end
    end
  endtask

  task automatic test_orphan;
    checks++; if (orphan_err != 0) begin failures++; $display("FAIL frame_err_alone got=%0d exp=0", orphan_err); end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_single;
    test_back_to_back;
    test_glitch;
    test_two_stop_err;
    test_break;
    test_reset_mid;
    test_fast;
    test_random;
    test_orphan;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
